// File: rtl/program_loader.sv
// Writer side of the instruction BRAM: assembles a length-prefixed, XOR-checksummed byte stream
// into 32-bit words and keeps the controller in reset until a verified program is loaded.
module program_loader #(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int INSTRUCTION_COUNT = 512,
    parameter int TIMEOUT_CYCLES    = 1_000_000
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic                                 start_in,
    input  logic [7:0]                           byte_in,
    input  logic                                 byte_valid_in,
    output logic                                 byte_ready_out,
    output logic                                 wr_en_out,
    output logic [$clog2(INSTRUCTION_COUNT)-1:0] wr_addr_out,
    output logic [INSTRUCTION_WIDTH-1:0]         wr_data_out,
    output logic                                 ctrl_rst_out,
    output logic                                 busy_out,
    output logic                                 done_out,
    output logic                                 error_out,
    output logic [1:0]                           error_code_out,
    output logic [15:0]                          instr_count_out
);

    localparam int AW = $clog2(INSTRUCTION_COUNT);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_LENGTH   = 2'b01;
    localparam logic [1:0] ERR_CHECKSUM = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    logic [2:0]                   state_q, state_d;
    logic [7:0]                   len_hi_q, len_hi_d;
    logic [15:0]                  count_q, count_d;
    logic [15:0]                  idx_q, idx_d;
    logic [1:0]                   byte_cnt_q, byte_cnt_d;
    logic [23:0]                  word_q, word_d;
    logic [7:0]                   csum_q, csum_d;
    logic [TW-1:0]                timer_q, timer_d;
    logic                         wr_en_q, wr_en_d;
    logic [AW-1:0]                wr_addr_q, wr_addr_d;
    logic [INSTRUCTION_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [1:0]                   err_code_q, err_code_d;

    logic        busy;
    logic        consume;
    logic        timeout;
    logic [15:0] len_n;

    assign busy    = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                     (state_q == S_DATA)   || (state_q == S_CHECK);
    assign consume = busy && byte_valid_in;
    assign timeout = busy && !consume && (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign len_n   = {len_hi_q, byte_in};

    always_comb begin
        state_d    = state_q;
        len_hi_d   = len_hi_q;
        count_d    = count_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        csum_d     = csum_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        err_code_d = err_code_q;
        // The idle timer only runs mid-load and is zero whenever a byte lands.
        timer_d    = (busy && !consume) ? timer_q + TW'(1) : '0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start_in) begin
                    state_d    = S_LEN_HI;
                    err_code_d = ERR_NONE;
                    idx_d      = '0;
                    csum_d     = '0;
                    byte_cnt_d = '0;
                end
            end
            S_LEN_HI: begin
                if (consume) begin
                    len_hi_d = byte_in;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (consume) begin
                    count_d = len_n;
                    if (len_n > 16'(INSTRUCTION_COUNT)) begin
                        state_d    = S_ERROR;
                        err_code_d = ERR_LENGTH;
                    end else if (len_n == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (consume) begin
                    csum_d     = csum_q ^ byte_in;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    word_d     = {word_q[15:0], byte_in};
                    if (byte_cnt_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = {word_q, byte_in};
                        wr_addr_d = idx_q[AW-1:0];
                        idx_d     = idx_q + 16'd1;
                        if (idx_q == count_q - 16'd1) begin
                            state_d = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (consume) begin
                    if (byte_in == csum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d    = S_ERROR;
                        err_code_d = ERR_CHECKSUM;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (timeout) begin
            state_d    = S_ERROR;
            err_code_d = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= S_IDLE;
            len_hi_q   <= '0;
            count_q    <= '0;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            csum_q     <= '0;
            timer_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            len_hi_q   <= len_hi_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            csum_q     <= csum_d;
            timer_q    <= timer_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            err_code_q <= err_code_d;
        end
    end

    // Only a verified program releases the controller; every other state holds it in reset.
    assign byte_ready_out  = busy;
    assign busy_out        = busy;
    assign done_out        = (state_q == S_DONE);
    assign error_out       = (state_q == S_ERROR);
    assign ctrl_rst_out    = (state_q != S_DONE);
    assign error_code_out  = err_code_q;
    assign instr_count_out = count_q;
    assign wr_en_out       = wr_en_q;
    assign wr_addr_out     = wr_addr_q;
    assign wr_data_out     = wr_data_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomised loads of program_loader checked against a word-list/XOR reference model
// and a shadow BRAM filled from the write port.
module tb_program_loader;

    localparam int ICOUNT = 512;
    localparam int TOUT   = 16;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        start_in = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid_in = 1'b0;
    logic        byte_ready_out;
    logic        wr_en_out;
    logic [8:0]  wr_addr_out;
    logic [31:0] wr_data_out;
    logic        ctrl_rst_out;
    logic        busy_out;
    logic        done_out;
    logic        error_out;
    logic [1:0]  error_code_out;
    logic [15:0] instr_count_out;

    int vectors = 0;
    int miscompares = 0;
    int wrPulses = 0;
    logic [31:0] mem [ICOUNT];
    logic [31:0] prog [$];

    program_loader #(
        .INSTRUCTION_WIDTH(32),
        .INSTRUCTION_COUNT(ICOUNT),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .start_in(start_in),
        .byte_in(byte_in),
        .byte_valid_in(byte_valid_in),
        .byte_ready_out(byte_ready_out),
        .wr_en_out(wr_en_out),
        .wr_addr_out(wr_addr_out),
        .wr_data_out(wr_data_out),
        .ctrl_rst_out(ctrl_rst_out),
        .busy_out(busy_out),
        .done_out(done_out),
        .error_out(error_out),
        .error_code_out(error_code_out),
        .instr_count_out(instr_count_out)
    );

    always #5 clk_in = ~clk_in;

    // Shadow BRAM: whatever the loader writes lands here for later comparison with the program.
    always @(negedge clk_in) begin
        if (wr_en_out) begin
            wrPulses = wrPulses + 1;
            mem[wr_addr_out] = wr_data_out;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int pickGap(input int maxGap);
        return (maxGap == 0) ? 0 : int'($urandom_range(maxGap, 0));
    endfunction

    // Offers one byte after an idle gap and returns one cycle after it has been taken.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        int waited = 0;
        byte_valid_in = 1'b0;
        repeat (gap) begin @(posedge clk_in); #1; end
        byte_in = b;
        byte_valid_in = 1'b1;
        while (!byte_ready_out && waited < 20) begin
            @(posedge clk_in); #1;
            waited++;
        end
        if (!byte_ready_out) checkOutput("byteReadyWait", 32'(byte_ready_out), 32'd1);
        @(posedge clk_in); #1;
        byte_valid_in = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ":ctrlRst"},  32'(ctrl_rst_out), 32'd1);
        checkOutput({tag, ":busy"},     32'(busy_out), 32'd0);
        checkOutput({tag, ":ready"},    32'(byte_ready_out), 32'd0);
        checkOutput({tag, ":done"},     32'(done_out), 32'd0);
        checkOutput({tag, ":error"},    32'(error_out), 32'd0);
        checkOutput({tag, ":code"},     32'(error_code_out), 32'd0);
        checkOutput({tag, ":count"},    32'(instr_count_out), 32'd0);
        checkOutput({tag, ":wrEn"},     32'(wr_en_out), 32'd0);
        checkOutput({tag, ":wrAddr"},   32'(wr_addr_out), 32'd0);
        checkOutput({tag, ":wrData"},   wr_data_out, 32'd0);
    endtask

    // A byte offered alongside start must be ignored; LEN_HI is entered on the next edge.
    task automatic startLoad(input string tag);
        start_in = 1'b1;
        byte_in = 8'hEE;
        byte_valid_in = 1'b1;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        byte_valid_in = 1'b0;
        checkOutput({tag, ":startBusy"},  32'(busy_out), 32'd1);
        checkOutput({tag, ":startRst"},   32'(ctrl_rst_out), 32'd1);
        checkOutput({tag, ":startDone"},  32'(done_out), 32'd0);
        checkOutput({tag, ":startErr"},   32'(error_out), 32'd0);
        checkOutput({tag, ":startCode"},  32'(error_code_out), 32'd0);
    endtask

    // Sends header, the words in prog[0..n-1] and (XOR of data bytes ^ delta); checks against the model.
    task automatic runLoad(input string tag, input int n, input logic [7:0] delta, input int maxGap);
        logic [7:0]  csum = 8'h00;
        logic [15:0] n16;
        logic [7:0]  b;
        int base;
        n16 = 16'(n);
        startLoad(tag);
        base = wrPulses;
        applyStimulus(n16[15:8], pickGap(maxGap));
        applyStimulus(n16[7:0], pickGap(maxGap));
        checkOutput({tag, ":instrCount"}, 32'(instr_count_out), 32'(n16));
        if (n > ICOUNT) begin
            checkOutput({tag, ":lenErr"},     32'(error_out), 32'd1);
            checkOutput({tag, ":lenCode"},    32'(error_code_out), 32'd1);
            checkOutput({tag, ":lenCtrlRst"}, 32'(ctrl_rst_out), 32'd1);
            checkOutput({tag, ":lenWrites"},  32'(wrPulses - base), 32'd0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'(prog[i] >> (24 - 8 * k));
                csum = csum ^ b;
                applyStimulus(b, pickGap(maxGap));
                if (k == 3) begin
                    checkOutput({tag, ":wrEn"},   32'(wr_en_out), 32'd1);
                    checkOutput({tag, ":wrAddr"}, 32'(wr_addr_out), 32'(i));
                    checkOutput({tag, ":wrData"}, wr_data_out, prog[i]);
                end else if (i == 0) begin
                    checkOutput({tag, ":noWrEn"}, 32'(wr_en_out), 32'd0);
                end
            end
        end
        applyStimulus(csum ^ delta, pickGap(maxGap));
        checkOutput({tag, ":writes"},  32'(wrPulses - base), 32'(n));
        checkOutput({tag, ":busy"},    32'(busy_out), 32'd0);
        checkOutput({tag, ":done"},    32'(done_out), (delta == 8'h00) ? 32'd1 : 32'd0);
        checkOutput({tag, ":error"},   32'(error_out), (delta == 8'h00) ? 32'd0 : 32'd1);
        checkOutput({tag, ":code"},    32'(error_code_out), (delta == 8'h00) ? 32'd0 : 32'd2);
        checkOutput({tag, ":ctrlRst"}, 32'(ctrl_rst_out), (delta == 8'h00) ? 32'd0 : 32'd1);
    endtask

    task automatic checkMemory(input string tag, input int n);
        for (int i = 0; i < n; i++) checkOutput({tag, ":mem"}, mem[i], prog[i]);
    endtask

    task automatic randomProgram(input int n);
        prog.delete();
        for (int i = 0; i < n; i++) prog.push_back($urandom);
    endtask

    initial begin
        int cycles;
        int firstErr;
        int n;

        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        checkResetValues("reset");

        // Two-word program; data bytes XOR to 0x10.
        prog.delete();
        prog.push_back(32'h3010_0020);
        prog.push_back(32'h1000_0000);
        runLoad("twoWords", 2, 8'h00, 0);
        checkMemory("twoWords", 2);

        runLoad("empty", 0, 8'h00, 0);

        runLoad("tooLong", 513, 8'h00, 0);

        // Same program, corrupted checksum byte (0x21 instead of 0x10).
        runLoad("badSum", 2, 8'h31, 0);

        // Stall after two data bytes and measure how long until the abort.
        startLoad("timeout");
        applyStimulus(8'h00, 0);
        applyStimulus(8'h01, 0);
        applyStimulus(8'hAB, 0);
        applyStimulus(8'hCD, 0);
        cycles = 0;
        firstErr = 0;
        while (firstErr == 0 && cycles < 40) begin
            @(posedge clk_in); #1;
            cycles++;
            if (error_out) firstErr = cycles;
        end
        checkOutput("timeout:latency", 32'(firstErr), 32'(TOUT));
        checkOutput("timeout:code",    32'(error_code_out), 32'd3);
        checkOutput("timeout:ctrlRst", 32'(ctrl_rst_out), 32'd1);

        // Reset in the middle of DATA, then a fresh randomised load.
        n = int'($urandom_range(8, 3));
        randomProgram(n);
        startLoad("midReset");
        applyStimulus(8'(n >> 8), pickGap(3));
        applyStimulus(8'(n), pickGap(3));
        for (int k = 0; k < 6; k++) applyStimulus(8'($urandom), pickGap(3));
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        checkResetValues("midReset");
        for (int r = 0; r < 3; r++) begin
            n = int'($urandom_range(20, 1));
            randomProgram(n);
            runLoad("random", n, 8'h00, 4);
            checkMemory("random", n);
        end

        // Largest accepted program fills every BRAM word.
        randomProgram(ICOUNT);
        runLoad("fullDepth", ICOUNT, 8'h00, 0);
        checkMemory("fullDepth", ICOUNT);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
